// File: rtl/led_matrix_scanner.sv
// Row-scanned 8x8 LED matrix driver with double-buffered frame storage and tear-free swaps.
// Optional PWM-style dimming is compiled in when LED_MATRIX_DIM_EN is defined.
module led_matrix_scanner #(
    parameter int ROW_PERIOD_CYCLES = 3375,
    parameter int BLANK_CYCLES      = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_pending,
    input  logic [2:0] brightness,
    output logic [7:0] row,
    output logic [7:0] d,
    output logic       frame_start
);

    localparam int CW = $clog2(ROW_PERIOD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(ROW_PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [7:0]    buf_q [2][8];
    logic [7:0]    buf_d [2][8];
    logic          front_sel_q, front_sel_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          swap_pending_q, swap_pending_d;
    logic [7:0]    row_q, row_d;
    logic [7:0]    d_q, d_d;
    logic          frame_start_q, frame_start_d;
    logic          wr_accept;
    logic          boundary;
    logic          lit_window;

`ifdef LED_MATRIX_DIM_EN
    localparam int SUB = (ROW_PERIOD_CYCLES - BLANK_CYCLES) / 8;
    logic [2:0] bright_q, bright_d;

    // Level is latched on counter 0 (always blank) so a slot is never split.
    always_comb begin
        bright_d   = (cnt_q == '0) ? brightness : bright_q;
        lit_window = ({1'b0, cnt_q - CNT_BLANK} < (CW+1)'((int'(bright_q) + 1) * SUB));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) bright_q <= '0;
        else          bright_q <= bright_d;
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign lit_window        = 1'b1;
`endif

    always_comb begin
        wr_accept = wr_valid && !swap_pending_q;
        boundary  = (cnt_q == CNT_LAST) && (idx_q == 3'd7);

        buf_d = buf_q;
        if (wr_accept) buf_d[~front_sel_q][wr_row] = wr_data;

        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        idx_d = (cnt_q == CNT_LAST) ? idx_q + 3'd1 : idx_q;

        // The swap decision uses the registered flag, so a request on the boundary waits a frame.
        front_sel_d    = front_sel_q ^ (boundary && swap_pending_q);
        swap_pending_d = swap_pending_q;
        if (boundary && swap_pending_q) swap_pending_d = 1'b0;
        else if (swap_req)              swap_pending_d = 1'b1;

        if (cnt_q < CNT_BLANK) begin
            row_d = 8'hFF;
            d_d   = 8'h00;
        end else begin
            row_d = ~(8'h01 << idx_q);
            d_d   = lit_window ? buf_q[front_sel_q][idx_q] : 8'h00;
        end
        frame_start_d = (cnt_q == '0) && (idx_q == 3'd0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    buf_q[b][i] <= 8'h00;
                end
            end
            front_sel_q    <= 1'b0;
            idx_q          <= 3'd0;
            cnt_q          <= '0;
            swap_pending_q <= 1'b0;
            row_q          <= 8'hFF;
            d_q            <= 8'h00;
            frame_start_q  <= 1'b0;
        end else begin
            buf_q          <= buf_d;
            front_sel_q    <= front_sel_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            swap_pending_q <= swap_pending_d;
            row_q          <= row_d;
            d_q            <= d_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign wr_ready     = ~swap_pending_q;
    assign swap_pending = swap_pending_q;
    assign row          = row_q;
    assign d            = d_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with ROW_PERIOD_CYCLES=40, BLANK_CYCLES=8.
// Time t counts clock edges since reset release; outputs at t reflect counter state t-1.
module tb_led_matrix_scanner;

    localparam int P = 40;
    localparam int B = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_pending;
    logic [2:0] brightness;
    logic [7:0] row;
    logic [7:0] d;
    logic       frame_start;

    int t;
    int total;
    int bad;

    typedef struct {
        int         t;
        logic [7:0] row;
        logic [7:0] d;
        logic       fs;
    } vec_t;

    vec_t tbl [13];

    led_matrix_scanner #(.ROW_PERIOD_CYCLES(P), .BLANK_CYCLES(B)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .brightness   (brightness),
        .row          (row),
        .d            (d),
        .frame_start  (frame_start)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0d got=timeout want=finish", t);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
        t++;
    endtask

    task automatic run_to(input int target);
        if (target < t) begin
            total++;
            bad++;
            $display("FAIL run_to got=t%0d want=t%0d", t, target);
        end
        while (t < target) step();
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%02h want=%02h", name, t, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        wr_valid   = 1'b0;
        wr_row     = 3'd0;
        wr_data    = 8'h00;
        swap_req   = 1'b0;
        brightness = 3'd7;
        step();
        step();
        reset_n = 1'b1;
        t       = 0;
    endtask

    task automatic write_row(input int k, input logic [7:0] data);
        wr_valid = 1'b1;
        wr_row   = 3'(k);
        wr_data  = data;
        check("wr_ready_idle", {7'd0, wr_ready}, 8'h01);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    initial begin
        int lit_cnt;
        int exp_cnt;
        logic [7:0] exp_after;

        total = 0;
        bad   = 0;
        t     = 0;

        tbl[0]  = '{0,   8'hFF, 8'h00, 1'b0};
        tbl[1]  = '{1,   8'hFF, 8'h00, 1'b1};
        tbl[2]  = '{2,   8'hFF, 8'h00, 1'b0};
        tbl[3]  = '{8,   8'hFF, 8'h00, 1'b0};
        tbl[4]  = '{9,   8'hFE, 8'h00, 1'b0};
        tbl[5]  = '{40,  8'hFE, 8'h00, 1'b0};
        tbl[6]  = '{41,  8'hFF, 8'h00, 1'b0};
        tbl[7]  = '{49,  8'hFD, 8'h00, 1'b0};
        tbl[8]  = '{169, 8'hEF, 8'h00, 1'b0};
        tbl[9]  = '{289, 8'h7F, 8'h00, 1'b0};
        tbl[10] = '{320, 8'h7F, 8'h00, 1'b0};
        tbl[11] = '{321, 8'hFF, 8'h00, 1'b1};
        tbl[12] = '{322, 8'hFF, 8'h00, 1'b0};

        // Reset state and idle scan
        do_reset();
        check("rst_pending", {7'd0, swap_pending}, 8'h00);
        check("rst_wr_ready", {7'd0, wr_ready}, 8'h01);
        for (int i = 0; i < 13; i++) begin
            run_to(tbl[i].t);
            check("scan_row", row, tbl[i].row);
            check("scan_d", d, tbl[i].d);
            check("scan_fs", {7'd0, frame_start}, {7'd0, tbl[i].fs});
        end

        // Write then swap
        do_reset();
        for (int k = 0; k < 8; k++) write_row(k, 8'(1 << k));
        pulse_swap();
        check("swap_pending_set", {7'd0, swap_pending}, 8'h01);
        check("wr_ready_low", {7'd0, wr_ready}, 8'h00);
        run_to(20);
        check("old_front_d", d, 8'h00);
        check("old_front_row", row, 8'hFE);
        run_to(319);
        check("pending_before_bnd", {7'd0, swap_pending}, 8'h01);
        check("wr_ready_before_bnd", {7'd0, wr_ready}, 8'h00);
        run_to(320);
        check("pending_cleared", {7'd0, swap_pending}, 8'h00);
        check("wr_ready_back", {7'd0, wr_ready}, 8'h01);
        run_to(321);
        check("swap_fs", {7'd0, frame_start}, 8'h01);
        check("swap_fs_ready", {7'd0, wr_ready}, 8'h01);
        for (int k = 0; k < 8; k++) begin
            run_to(330 + P * k);
            check("new_row", row, ~(8'(1 << k)));
            check("new_d", d, 8'(1 << k));
        end

        // Swap requested on the boundary cycle itself
        for (int k = 0; k < 8; k++) write_row(k, ~(8'(1 << k)));
        run_to(639);
        pulse_swap();
        check("bnd_pending", {7'd0, swap_pending}, 8'h01);
        check("bnd_wr_ready", {7'd0, wr_ready}, 8'h00);
        run_to(650);
        check("bnd_not_yet", d, 8'h01);
        run_to(959);
        check("bnd_pending_hold", {7'd0, swap_pending}, 8'h01);
        run_to(960);
        check("bnd_applied", {7'd0, swap_pending}, 8'h00);
        for (int k = 0; k < 8; k++) begin
            run_to(970 + P * k);
            check("bnd_new_d", d, ~(8'(1 << k)));
        end

        // Write held off while a swap is pending
        pulse_swap();
        wr_valid = 1'b1;
        wr_row   = 3'd3;
        wr_data  = 8'hAA;
        check("blk_ready_low", {7'd0, wr_ready}, 8'h00);
        run_to(1279);
        check("blk_ready_still_low", {7'd0, wr_ready}, 8'h00);
        run_to(1280);
        check("blk_ready_high", {7'd0, wr_ready}, 8'h01);
        step();
        wr_valid = 1'b0;
        run_to(1410);
        check("blk_front_untouched", d, 8'h08);
        pulse_swap();
        run_to(1690);
        check("blk_back_row2", d, 8'hFB);
        run_to(1730);
        check("blk_back_row3", d, 8'hAA);

        // Reset in the middle of the idx-4 lit phase with a swap pending
        pulse_swap();
        check("mid_pending", {7'd0, swap_pending}, 8'h01);
        run_to(1771);
        check("mid_row_pre", row, 8'hEF);
        check("mid_d_pre", d, 8'hEF);
        reset_n = 1'b0;
        #1;
        check("mid_row_async", row, 8'hFF);
        check("mid_d_async", d, 8'h00);
        check("mid_pending_async", {7'd0, swap_pending}, 8'h00);
        check("mid_ready_async", {7'd0, wr_ready}, 8'h01);
        do_reset();
        run_to(1);
        check("mid_fs", {7'd0, frame_start}, 8'h01);
        run_to(8);
        check("mid_blank", row, 8'hFF);
        run_to(9);
        check("mid_row0", row, 8'hFE);
        check("mid_d_cleared", d, 8'h00);
        run_to(10);
        write_row(0, 8'h5A);
        check("mid_no_pending", {7'd0, swap_pending}, 8'h00);
        run_to(330);
        check("mid_no_swap", d, 8'h00);

        // Dimming at brightness 1
        brightness = 3'd1;
        pulse_swap();
`ifdef LED_MATRIX_DIM_EN
        exp_cnt   = 8;
        exp_after = 8'h00;
`else
        exp_cnt   = 32;
        exp_after = 8'h5A;
`endif
        lit_cnt = 0;
        for (int tt = 641; tt <= 680; tt++) begin
            run_to(tt);
            if (d == 8'h5A) lit_cnt++;
            if (tt == 648) check("dim_blank_end", d, 8'h00);
            if (tt == 649) check("dim_first_lit", d, 8'h5A);
            if (tt == 656) check("dim_last_sub", d, 8'h5A);
            if (tt == 657) check("dim_after_sub", d, exp_after);
            if (tt == 680) check("dim_slot_end", d, exp_after);
        end
        check("dim_lit_cycles", 8'(lit_cnt), 8'(exp_cnt));
        run_to(681);
        check("dim_next_blank_row", row, 8'hFF);
        check("dim_next_blank_d", d, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Time-multiplexed driver for the 8×8 LED matrix on the board's `row`/`d` pins. It holds a double-buffered 8×8 frame written by the CPU's memory-mapped IO side. It scans one row at a time with a blanking gap between rows to suppress ghosting. A buffer swap is committed only at a frame boundary, so the display never tears.

## Interface
Parameters:
- `ROW_PERIOD_CYCLES`, default 3375: clock cycles per row slot, which gives 1 kHz frame rate at 27 MHz. Must be ≥ `BLANK_CYCLES` + 8.
- `BLANK_CYCLES`, default 16: cycles at the start of each row slot with all rows off. Must be ≥ 1.

Ports:
- `clock` in 1: system clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `wr_valid` in 1: a write to the back buffer is offered.
- `wr_ready` out 1: a write can be accepted. Low while a swap is pending.
- `wr_row` in 3: back-buffer row index for the write.
- `wr_data` in 8: column bits for that row. Bit 1 means lit.
- `swap_req` in 1: single-cycle pulse requesting a front/back swap.
- `swap_pending` out 1: a swap is latched and not yet applied.
- `brightness` in 3: global brightness level. Used only with `LED_MATRIX_DIM_EN`.
- `row` out 8: row select, active-low. 0 drives the row.
- `d` out 8: column data, active-high.
- `frame_start` out 1: one-cycle pulse on the first cycle of each row-0 slot.

## Operation
- Storage is two 8×8-bit buffers; `front_sel` selects which one is scanned.
- **Reset:**
  - both buffers are 0, `front_sel` = 0, scan index = 0, slot counter = 0;
  - outputs: `row` = 8'hFF, `d` = 0, `frame_start` = 0, `swap_pending` = 0, `wr_ready` = 1.
- **Write:**
  - A write is accepted when `wr_valid && wr_ready`.
  - The accepted write stores `back[wr_row] <= wr_data` at the next edge.
  - Writes never touch the front buffer.
- **Swap request:**
  - `swap_req` with `swap_pending` = 0 sets `swap_pending` at the next edge.
  - `swap_req` while pending is ignored; requests do not stack.
- **Scan, per row slot of `ROW_PERIOD_CYCLES` cycles:**
  - The slot counter runs 0 … `ROW_PERIOD_CYCLES`−1, then wraps.
  - Blank phase, counter < `BLANK_CYCLES`: `row` = 8'hFF, `d` = 0.
  - Lit phase, all remaining cycles: `row` = ~(1 << idx), `d` = front[idx].
  - At counter wrap, idx increments modulo 8.
- **Frame boundary** is the last cycle of the idx = 7 slot. On that cycle:
  - if the registered `swap_pending` = 1, toggle `front_sel` and clear `swap_pending`;
  - the next cycle is counter 0 of idx 0, and `frame_start` = 1 on that cycle.
- After a swap, the back buffer holds the previous front contents. There is no copy; software rewrites every row it cares about.

## Timing
- `row`, `d` and `frame_start` are registered: values derived from counter state n appear one cycle later. This one-cycle lag is uniform, so slot lengths are exact.
- Front-buffer data changes only at row-0 slot start, never mid-frame.
- Simultaneous events:
  - `swap_req` arriving on the frame-boundary cycle itself is latched but applied at the following frame boundary.
  - `wr_valid` and `swap_req` in the same cycle with no swap pending: the write is accepted into the current back buffer before the swap.
  - `wr_ready` falls the cycle after `swap_req` is accepted, and rises the cycle after the swap is applied.
- Worst-case swap latency is 8×`ROW_PERIOD_CYCLES` + 1 cycles.
- Asserting `reset_n` mid-frame forces all outputs to their reset values immediately (asynchronous). Scanning restarts at idx 0, counter 0, and a pending swap is discarded.

## Configuration
- `LED_MATRIX_DIM_EN` defined:
  - SUB = (`ROW_PERIOD_CYCLES` − `BLANK_CYCLES`) / 8, using integer division.
  - Within the lit phase, `d` = front[idx] only while (counter − `BLANK_CYCLES`) < (`brightness`+1)·SUB; otherwise `d` = 0.
  - `row` stays asserted for the whole lit phase.
  - `brightness` is sampled at each slot start, so a change never splits a slot.
- `LED_MATRIX_DIM_EN` undefined:
  - `brightness` is ignored, and `d` is held for the full lit phase (equivalent to level 7).

## Test plan
All cases use `ROW_PERIOD_CYCLES` = 40, `BLANK_CYCLES` = 8.
- **Reset state:** release `reset_n`, run 320 cycles.
  - Required: `row` is 8'hFF for cycles 0–8 of each slot, then walks FE, FD, …, 7F; `d` stays 0.
  - Required: `frame_start` pulses every 320 cycles.
- **Write then swap:** write rows 0–7 with 8'h01, 8'h02, …, 8'h80, then pulse `swap_req`.
  - Required: `wr_ready` goes low; the next frame shows row k with `d` = 1<<k.
  - Required: `swap_pending` clears on the boundary cycle, and `wr_ready` is back to 1 at `frame_start`.
- **Swap on the boundary:** pulse `swap_req` exactly on the last cycle of the idx-7 slot.
  - Required: the new data appears one full frame later (640 cycles), not 320.
- **Blocked write:** hold `wr_valid` with `wr_row` = 3, `wr_data` = 8'hAA while a swap is pending.
  - Required: nothing is written until `wr_ready` = 1; then row 3 of the new back buffer = 8'hAA.
- **Mid-scan reset:** assert `reset_n` = 0 during the idx-4 lit phase.
  - Required: `row` = 8'hFF and `d` = 0 within the same cycle; after release, idx-0 blanking starts, and a pending swap is gone.
- **Dimming, with `LED_MATRIX_DIM_EN` and `brightness` = 1:**
  - Required: `d` is lit for exactly 8 cycles after blanking (SUB = 4), then 0 for 24 cycles.
  - Required: without the macro, `d` is lit for all 32 cycles.
